// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and the data RAM.
// Runs one access per request through IDLE -> ACCESS|FAULT -> DONE, drives
// big-endian byte lanes to the RAM and extends load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_FAULT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        misaligned_q;
  logic [31:0] rdata_q;

  logic        is_store;
  logic        req_aligned;
  logic        accept;
  logic        access_active;
  logic [3:0]  lane_sel;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  // Stores are the three top opcodes; everything at or below LW is a load.
  assign is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
  assign accept   = (state_q == S_IDLE) && req_i;

  // Alignment check on the incoming request, decided before it is latched.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    req_aligned = 1'b1;
    case (op_i)
      OP_LH, OP_LHU, OP_SH: req_aligned = ~addr_i[0];
      OP_LW, OP_SW:         req_aligned = (addr_i[1:0] == 2'b00);
      default:              req_aligned = 1'b1;
    endcase
  end

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request capture: op, address, data and misalignment are frozen at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
    end else if (accept) begin
      op_q         <= op_i;
      addr_q       <= addr_i;
      wdata_q      <= wdata_i;
      misaligned_q <= ~req_aligned;
    end
  end

  // Load result register, written only at the end of a load ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst)                                  rdata_q <= 32'h0;
    else if (state_q == S_ACCESS && !is_store) rdata_q <= load_data;
  end

  // Next-state logic and the control outputs, all suppressed while reset is high.
  always_comb begin
    state_d    = state_q;
    done_o     = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stallreq_o = req_i;
        if (req_i) state_d = req_aligned ? S_ACCESS : S_FAULT;
      end
      S_ACCESS: begin
        stallreq_o = 1'b1;
        state_d    = S_DONE;
      end
      S_FAULT: begin
        stallreq_o = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        adel_o  = misaligned_q & ~is_store;
        ades_o  = misaligned_q &  is_store;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      done_o     = 1'b0;
      adel_o     = 1'b0;
      ades_o     = 1'b0;
      stallreq_o = 1'b0;
    end
  end

  // Byte-lane selects and replicated store data from the latched request.
  always_comb begin
    lane_sel  = 4'b1111;
    lane_data = wdata_q;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: begin
        lane_sel  = 4'b1000 >> addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        lane_sel  = addr_q[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_sel  = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  // Load extraction: big-endian lane pick followed by sign or zero extension.
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte   = 8'h00;
    ld_half   = 16'h0000;
    load_data = mem_data_i;
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_data_i[31:24];
      2'd1:    ld_byte = mem_data_i[23:16];
      2'd2:    ld_byte = mem_data_i[15:8];
      default: ld_byte = mem_data_i[7:0];
    endcase
    ld_half = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      default: load_data = mem_data_i;
    endcase
  end

  // RAM port is live only in ACCESS, and reset kills it in the same cycle.
  assign access_active = (state_q == S_ACCESS) && !rst;
  assign mem_ce_o      = access_active;
  assign mem_we_o      = access_active && is_store;
  assign mem_addr_o    = access_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_sel_o     = access_active ? lane_sel : 4'b0000;
  assign mem_data_o    = (access_active && is_store) ? lane_data : 32'h0;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-lane RAM model.
module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011;
  localparam logic [2:0] LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        clk, rst, req_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        done_o, stallreq_o, adel_o, ades_o, mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [3:0]  mem_sel_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [0:255];

  // Per-cycle captures from run_access: cycle 0 = request, 1 = ACCESS/FAULT, 2 = DONE.
  logic        c0_stall, c1_ce, c1_we, c1_stall, c1_done, c2_done, c2_adel, c2_ades, c2_stall, c2_ce;
  logic [3:0]  c1_sel;
  logic [31:0] c1_addr, c1_data, c2_rdata;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .stallreq_o(stallreq_o),
    .adel_o(adel_o), .ades_o(ades_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: word i holds 0x0BAD0000 | i until written.
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0BAD_0000 | 32'(i);
  end

  assign mem_data_i = ram[mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (mem_ce_o && mem_we_o) begin
      if (mem_sel_o[3]) ram[mem_addr_o[9:2]][31:24] <= mem_data_o[31:24];
      if (mem_sel_o[2]) ram[mem_addr_o[9:2]][23:16] <= mem_data_o[23:16];
      if (mem_sel_o[1]) ram[mem_addr_o[9:2]][15:8]  <= mem_data_o[15:8];
      if (mem_sel_o[0]) ram[mem_addr_o[9:2]][7:0]   <= mem_data_o[7:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request, then scrambled inputs to prove the latched copy is used.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata;
    #1 c0_stall = stallreq_o;
    @(negedge clk);
    c1_ce = mem_ce_o; c1_we = mem_we_o; c1_sel = mem_sel_o; c1_addr = mem_addr_o;
    c1_data = mem_data_o; c1_stall = stallreq_o; c1_done = done_o;
    req_i = 1'b0; op_i = ~op; addr_i = ~addr; wdata_i = ~wdata;
    @(negedge clk);
    c2_done = done_o; c2_adel = adel_o; c2_ades = ades_o; c2_stall = stallreq_o;
    c2_ce = mem_ce_o; c2_rdata = rdata_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b0; op_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    n_vec++; if ({done_o, adel_o, ades_o, stallreq_o} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {done_o, adel_o, ades_o, stallreq_o}); end
    n_vec++; if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o} !== 70'h0) begin n_err++; $display("FAIL reset_mem: got ce=%b we=%b sel=%b addr=%h data=%h want all 0", mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o); end
  endtask

  task automatic test_word();
    run_access(SW, 32'h100, 32'h1122_3344);
    n_vec++; if ({c1_ce, c1_we} !== 2'b11) begin n_err++; $display("FAIL sw_ce_we: got %b want 11", {c1_ce, c1_we}); end
    n_vec++; if (c1_sel !== 4'b1111) begin n_err++; $display("FAIL sw_sel: got %b want 1111", c1_sel); end
    n_vec++; if (c1_addr !== 32'h100) begin n_err++; $display("FAIL sw_addr: got %h want 00000100", c1_addr); end
    n_vec++; if (c1_data !== 32'h1122_3344) begin n_err++; $display("FAIL sw_data: got %h want 11223344", c1_data); end
    n_vec++; if ({c0_stall, c1_stall, c2_stall} !== 3'b110) begin n_err++; $display("FAIL sw_stall: got %b want 110", {c0_stall, c1_stall, c2_stall}); end
    n_vec++; if ({c1_done, c2_done, c2_ce} !== 3'b010) begin n_err++; $display("FAIL sw_done: got %b want 010", {c1_done, c2_done, c2_ce}); end
    run_access(LW, 32'h100, 32'h0);
    n_vec++; if ({c1_ce, c1_we} !== 2'b10) begin n_err++; $display("FAIL lw_ce_we: got %b want 10", {c1_ce, c1_we}); end
    n_vec++; if (c2_rdata !== 32'h1122_3344) begin n_err++; $display("FAIL lw_rdata: got %h want 11223344", c2_rdata); end
    n_vec++; if ({c0_stall, c1_stall, c2_stall, c2_done} !== 4'b1101) begin n_err++; $display("FAIL lw_stall_done: got %b want 1101", {c0_stall, c1_stall, c2_stall, c2_done}); end
  endtask

  task automatic test_byte();
    run_access(SB, 32'h103, 32'h0000_00A5);
    n_vec++; if (c1_sel !== 4'b0001) begin n_err++; $display("FAIL sb_sel: got %b want 0001", c1_sel); end
    n_vec++; if (c1_data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_data: got %h want a5a5a5a5", c1_data); end
    n_vec++; if (c1_addr !== 32'h100) begin n_err++; $display("FAIL sb_addr: got %h want 00000100", c1_addr); end
    run_access(LB, 32'h103, 32'h0);
    n_vec++; if (c2_rdata !== 32'hFFFF_FFA5) begin n_err++; $display("FAIL lb_rdata: got %h want ffffffa5", c2_rdata); end
    run_access(LBU, 32'h103, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL lbu_rdata: got %h want 000000a5", c2_rdata); end
    run_access(LB, 32'h101, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0000_0022) begin n_err++; $display("FAIL lb1_rdata: got %h want 00000022", c2_rdata); end
  endtask

  task automatic test_half();
    run_access(SH, 32'h102, 32'h0000_8001);
    n_vec++; if (c1_sel !== 4'b0011) begin n_err++; $display("FAIL sh_sel: got %b want 0011", c1_sel); end
    n_vec++; if (c1_data !== 32'h8001_8001) begin n_err++; $display("FAIL sh_data: got %h want 80018001", c1_data); end
    run_access(LH, 32'h102, 32'h0);
    n_vec++; if (c2_rdata !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_rdata: got %h want ffff8001", c2_rdata); end
    run_access(LHU, 32'h102, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_rdata: got %h want 00008001", c2_rdata); end
    run_access(LH, 32'h100, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0000_1122) begin n_err++; $display("FAIL lh_upper: got %h want 00001122", c2_rdata); end
  endtask

  task automatic test_misaligned();
    run_access(LW, 32'h101, 32'h0);
    n_vec++; if (c1_ce !== 1'b0) begin n_err++; $display("FAIL adel_ce: got %b want 0", c1_ce); end
    n_vec++; if ({c1_stall, c1_done} !== 2'b10) begin n_err++; $display("FAIL adel_fault_cycle: got %b want 10", {c1_stall, c1_done}); end
    n_vec++; if ({c2_done, c2_adel, c2_ades} !== 3'b110) begin n_err++; $display("FAIL adel_flags: got %b want 110", {c2_done, c2_adel, c2_ades}); end
    n_vec++; if (c2_rdata !== 32'h0000_1122) begin n_err++; $display("FAIL adel_rdata_hold: got %h want 00001122", c2_rdata); end
    run_access(SH, 32'h201, 32'h0000_FFFF);
    n_vec++; if ({c1_ce, c1_we} !== 2'b00) begin n_err++; $display("FAIL ades_ce_we: got %b want 00", {c1_ce, c1_we}); end
    n_vec++; if ({c2_done, c2_adel, c2_ades} !== 3'b101) begin n_err++; $display("FAIL ades_flags: got %b want 101", {c2_done, c2_adel, c2_ades}); end
    run_access(LW, 32'h200, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0BAD_0080) begin n_err++; $display("FAIL ades_ram_intact: got %h want 0bad0080", c2_rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_i = 1'b1; op_i = LW; addr_i = 32'h100; wdata_i = 32'h0;
    @(negedge clk);
    n_vec++; if (mem_ce_o !== 1'b1) begin n_err++; $display("FAIL b2b_first_ce: got %b want 1", mem_ce_o); end
    @(negedge clk);
    n_vec++; if ({done_o, mem_ce_o, stallreq_o} !== 3'b100) begin n_err++; $display("FAIL b2b_done: got %b want 100", {done_o, mem_ce_o, stallreq_o}); end
    addr_i = 32'h300;
    @(negedge clk);
    n_vec++; if ({done_o, mem_ce_o, stallreq_o} !== 3'b001) begin n_err++; $display("FAIL b2b_idle_accept: got %b want 001", {done_o, mem_ce_o, stallreq_o}); end
    @(negedge clk);
    n_vec++; if (mem_ce_o !== 1'b1 || mem_addr_o !== 32'h300) begin n_err++; $display("FAIL b2b_second_access: got ce=%b addr=%h want ce=1 addr=00000300", mem_ce_o, mem_addr_o); end
    req_i = 1'b0;
    @(negedge clk);
    n_vec++; if (done_o !== 1'b1 || rdata_o !== 32'h0BAD_00C0) begin n_err++; $display("FAIL b2b_second_done: got done=%b rdata=%h want done=1 rdata=0bad00c0", done_o, rdata_o); end
  endtask

  task automatic test_reset_in_access();
    @(negedge clk);
    req_i = 1'b1; op_i = SW; addr_i = 32'h300; wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if (mem_we_o !== 1'b1) begin n_err++; $display("FAIL rsta_pre_we: got %b want 1", mem_we_o); end
    rst = 1'b1; req_i = 1'b0;
    #1;
    n_vec++; if ({mem_ce_o, mem_we_o} !== 2'b00) begin n_err++; $display("FAIL rsta_we_killed: got %b want 00", {mem_ce_o, mem_we_o}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if ({rdata_o, done_o, adel_o, ades_o, stallreq_o} !== 36'h0) begin n_err++; $display("FAIL rsta_after_ctrl: got rdata=%h flags=%b want 0", rdata_o, {done_o, adel_o, ades_o, stallreq_o}); end
    n_vec++; if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o} !== 70'h0) begin n_err++; $display("FAIL rsta_after_mem: got ce=%b we=%b sel=%b addr=%h data=%h want 0", mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o); end
    @(negedge clk);
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rsta_no_done: got %b want 0", done_o); end
    run_access(LW, 32'h300, 32'h0);
    n_vec++; if (c2_rdata !== 32'h0BAD_00C0) begin n_err++; $display("FAIL rsta_ram_old: got %h want 0bad00c0", c2_rdata); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_in_access();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
